// File: rtl/alu_seq_pkg.sv
// Shared definitions: ALU opcodes plus the alu_seq command and state encodings.
package definitions;

  localparam logic [2:0] kADD  = 3'd0;
  localparam logic [2:0] kSUB  = 3'd1;
  localparam logic [2:0] kAND  = 3'd2;
  localparam logic [2:0] kOR   = 3'd3;
  localparam logic [2:0] kXOR  = 3'd4;
  localparam logic [2:0] kSLL  = 3'd5;
  localparam logic [2:0] kSRL  = 3'd6;
  localparam logic [2:0] kPASS = 3'd7;

  typedef enum logic [1:0] {
    CMD_ADD16 = 2'd0,
    CMD_SUB16 = 2'd1,
    CMD_NORM  = 2'd2,
    CMD_RSVD  = 2'd3
  } seq_cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    NORM = 3'd3,
    DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_seq.sv
// alu_seq: drives the 8-bit ALU over several passes for ADD16/SUB16/NORM.
// Optional feature macro: ALU_SEQ_NORM_EN (enables the NORM command).
`default_nettype none

module alu_seq
  import definitions::*;
#(
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [1:0]      REQ_CMD,
  input  logic [2*DW-1:0] REQ_A,
  input  logic [2*DW-1:0] REQ_B,
  output logic [2:0]      ALU_OP,
  output logic            ALU_CI,
  output logic [DW-1:0]   ALU_A,
  output logic [DW-1:0]   ALU_B,
  input  logic [DW-1:0]   ALU_OUT,
  input  logic            ALU_CO,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [2*DW-1:0] RSP_DATA,
  output logic            RSP_CO,
  output logic            RSP_ZERO,
  output logic [3:0]      RSP_CNT,
  output logic            RSP_ERR
);

  seq_state_t      state_q, state_d;
  seq_cmd_t        cmd_q, cmd_d;
  logic [2*DW-1:0] a_q, a_d;
  logic [2*DW-1:0] b_q, b_d;
  logic [2*DW-1:0] res_q, res_d;
  logic            carry_q, carry_d;
  logic            err_q, err_d;
  logic            is_sub;
  seq_cmd_t        req_cmd;

`ifdef ALU_SEQ_NORM_EN
  logic [DW-1:0]   w_q, w_d;
  logic [3:0]      cnt_q, cnt_d;
`endif

  assign req_cmd = seq_cmd_t'(REQ_CMD);
  assign is_sub  = (cmd_q == CMD_SUB16);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cmd_q   <= CMD_ADD16;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef ALU_SEQ_NORM_EN
      w_q     <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      err_q   <= err_d;
`ifdef ALU_SEQ_NORM_EN
      w_q     <= w_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    err_d   = err_q;
`ifdef ALU_SEQ_NORM_EN
    w_d     = w_q;
    cnt_d   = cnt_q;
`endif
    ALU_OP  = kADD;
    ALU_CI  = 1'b0;
    ALU_A   = '0;
    ALU_B   = '0;

    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          cmd_d   = req_cmd;
          a_d     = REQ_A;
          b_d     = REQ_B;
          res_d   = '0;
          carry_d = 1'b0;
          err_d   = 1'b0;
`ifdef ALU_SEQ_NORM_EN
          w_d     = REQ_A[DW-1:0];
          cnt_d   = '0;
`endif
          case (req_cmd)
            CMD_ADD16, CMD_SUB16: state_d = LO;
`ifdef ALU_SEQ_NORM_EN
            // A zero operand can never normalise; finish without entering NORM.
            CMD_NORM: state_d = (REQ_A[DW-1:0] == '0) ? DONE : NORM;
`endif
            default: begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          endcase
        end
      end

      // Subtract is A + ~B + 1 through kADD so the borrow chains as a carry.
      LO: begin
        ALU_OP  = kADD;
        ALU_A   = a_q[DW-1:0];
        ALU_B   = is_sub ? ~b_q[DW-1:0] : b_q[DW-1:0];
        ALU_CI  = is_sub;
        res_d[DW-1:0] = ALU_OUT;
        carry_d = ALU_CO;
        state_d = HI;
      end

      HI: begin
        ALU_OP  = kADD;
        ALU_A   = a_q[2*DW-1:DW];
        ALU_B   = is_sub ? ~b_q[2*DW-1:DW] : b_q[2*DW-1:DW];
        ALU_CI  = carry_q;
        res_d[2*DW-1:DW] = ALU_OUT;
        carry_d = ALU_CO;
        state_d = DONE;
      end

`ifdef ALU_SEQ_NORM_EN
      NORM: begin
        if (w_q == '0) begin
          res_d   = '0;
          state_d = DONE;
        end else if (w_q[DW-1]) begin
          res_d   = {{DW{1'b0}}, w_q};
          state_d = DONE;
        end else begin
          ALU_OP = kSLL;
          ALU_A  = w_q;
          w_d    = ALU_OUT;
          cnt_d  = cnt_q + 4'd1;
        end
      end
`endif

      DONE: begin
        if (RSP_READY) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign REQ_READY = (state_q == IDLE);
  assign RSP_VALID = (state_q == DONE);
  assign RSP_DATA  = res_q;
  assign RSP_CO    = carry_q;
  assign RSP_ERR   = err_q;
  // Gated by DONE so the cleared result does not flag zero while idle or in reset.
  assign RSP_ZERO  = RSP_VALID && (res_q == '0);
`ifdef ALU_SEQ_NORM_EN
  assign RSP_CNT   = cnt_q;
`else
  assign RSP_CNT   = 4'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with a behavioural 8-bit ALU.
`default_nettype none

module tb_alu_seq;
  import definitions::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_cmd = 2'd0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [2:0]  alu_op;
  logic        alu_ci;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_co;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_co, rsp_zero, rsp_err;
  logic [3:0]  rsp_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq #(.DW(8)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_CMD(req_cmd),
    .REQ_A(req_a), .REQ_B(req_b),
    .ALU_OP(alu_op), .ALU_CI(alu_ci), .ALU_A(alu_a), .ALU_B(alu_b),
    .ALU_OUT(alu_out), .ALU_CO(alu_co),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .RSP_CO(rsp_co), .RSP_ZERO(rsp_zero), .RSP_CNT(rsp_cnt), .RSP_ERR(rsp_err)
  );

  always_comb begin
    alu_out = 8'h00;
    alu_co  = 1'b0;
    case (alu_op)
      kADD:    {alu_co, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
      kSLL:    begin alu_out = {alu_a[6:0], 1'b0}; alu_co = alu_a[7]; end
      default: begin alu_out = 8'h00; alu_co = 1'b0; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called #1 after a rising edge with the sequencer idle.
  task automatic run_cmd(input string tag, input logic [1:0] cmd,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e_data, input logic e_co, input logic e_zero,
                         input logic [3:0] e_cnt, input logic e_err, input int e_lat);
    int lat;
    check({tag, ":rdy"}, req_ready, 1'b1);
    req_valid = 1'b1; req_cmd = cmd; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_cmd = 2'd0; req_a = ~a; req_b = ~b;
    wait_rsp(lat);
    check({tag, ":lat"}, lat, e_lat);
    check({tag, ":data"}, rsp_data, e_data);
    check({tag, ":co"}, rsp_co, e_co);
    check({tag, ":zero"}, rsp_zero, e_zero);
    check({tag, ":cnt"}, rsp_cnt, e_cnt);
    check({tag, ":err"}, rsp_err, e_err);
    check({tag, ":busy"}, req_ready, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, ":ret"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    int lat;
    #2;
    check("rst:valid", rsp_valid, 1'b0);
    check("rst:ready", req_ready, 1'b1);
    check("rst:rsp", {rsp_data, rsp_co, rsp_zero, rsp_cnt, rsp_err}, 24'h0);
    check("rst:alu", {alu_op, alu_ci, alu_a, alu_b}, {kADD, 17'h0});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd("add_12ff", 2'd0, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0, 4'd0, 1'b0, 3);
    run_cmd("add_ffff", 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b0, 3);
    run_cmd("sub_1000", 2'd1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 4'd0, 1'b0, 3);
    run_cmd("sub_0000", 2'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0, 3);
    run_cmd("add_8000", 2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 4'd0, 1'b0, 3);
    run_cmd("rsvd",     2'd3, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b1, 1);
`ifdef ALU_SEQ_NORM_EN
    run_cmd("norm_05",  2'd2, 16'hFF05, 16'h0000, 16'h00A0, 1'b0, 1'b0, 4'd5, 1'b0, 7);
    run_cmd("norm_80",  2'd2, 16'h0080, 16'h0000, 16'h0080, 1'b0, 1'b0, 4'd0, 1'b0, 2);
    run_cmd("norm_00",  2'd2, 16'h1200, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b0, 1);
    run_cmd("norm_01",  2'd2, 16'h0001, 16'h0000, 16'h0080, 1'b0, 1'b0, 4'd7, 1'b0, 9);
`else
    run_cmd("norm_off", 2'd2, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd0, 1'b1, 1);
`endif

    // Backpressure: REQ_VALID stays high (reserved cmd) throughout DONE.
    req_valid = 1'b1; req_cmd = 2'd0; req_a = 16'h1234; req_b = 16'h1111;
    @(posedge clk); #1;
    req_cmd = 2'd3; req_a = 16'hAAAA; req_b = 16'h5555;
    wait_rsp(lat);
    check("bp:lat", lat, 3);
    for (int i = 0; i < 4; i++) begin
      check("bp:hold", {rsp_valid, req_ready, rsp_data, rsp_err}, {2'b10, 16'h2345, 1'b0});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp:idle", {rsp_valid, req_ready}, 2'b01);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp:next", {rsp_valid, rsp_err, rsp_data}, {2'b11, 16'h0000});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset asserted while the ADD16 high byte is on the ALU.
    req_valid = 1'b1; req_cmd = 2'd0; req_a = 16'h12FF; req_b = 16'h0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("hi:alu", {alu_op, alu_ci, alu_a, alu_b}, {kADD, 1'b1, 8'h12, 8'h00});
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst:state", {rsp_valid, req_ready}, 2'b01);
    check("mid_rst:rsp", {rsp_data, rsp_co, rsp_zero, rsp_cnt, rsp_err}, 24'h0);
    check("mid_rst:alu", {alu_op, alu_ci, alu_a, alu_b}, {kADD, 17'h0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_rst:norsp", {rsp_valid, req_ready}, 2'b01);
    end
    run_cmd("add_after", 2'd0, 16'h00F0, 16'h0020, 16'h0110, 1'b0, 1'b0, 4'd0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that owns the 8-bit combinational ALU's control ports and uses it to execute commands wider or longer than one ALU pass: 16-bit add, 16-bit subtract and 8-bit normalize (shift left until MSB set). It sits between the decode/execute logic, which issues commands through a valid/ready request port, and the ALU instance. It drives ALU_OP, ALU_CI and the operands, captures ALU_OUT and ALU_CO, and returns results through a valid/ready response port.

## Interface
- DW, 8, ALU data width; the wide operands are 2*DW.
- CLK  in  1  clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  command present.
- REQ_READY  out  1  sequencer can accept; equals (state==IDLE).
- REQ_CMD  in  2  seq_cmd_t: 0 ADD16, 1 SUB16, 2 NORM, 3 reserved.
- REQ_A, REQ_B  in  2*DW  operands; NORM uses REQ_A[DW-1:0] only.
- ALU_OP  out  3  ALU opcode (kADD, kSLL from package).
- ALU_CI  out  1  ALU carry-in.
- ALU_A, ALU_B  out  DW  ALU operands.
- ALU_OUT  in  DW  ALU result, same cycle.
- ALU_CO  in  1  ALU carry-out.
- RSP_VALID  out  1  result available.
- RSP_READY  in  1  consumer takes result.
- RSP_DATA  out  2*DW  result; NORM zero-extends.
- RSP_CO  out  1  final carry; for SUB16, 1 means no borrow.
- RSP_ZERO  out  1  RSP_DATA==0.
- RSP_CNT  out  4  NORM shift count; 0 for other commands.
- RSP_ERR  out  1  command unsupported or reserved.

## Operation
- States: IDLE, LO, HI, NORM, DONE.
- IDLE: a request is accepted on an edge with REQ_VALID&&REQ_READY. The sequencer latches A, B and cmd, then moves to:
  - LO for ADD16/SUB16;
  - NORM for NORM;
  - DONE with RSP_ERR=1 and RSP_DATA=0 for cmd 3.
- ADD16, LO state: ALU_OP=kADD, ALU_A=A[7:0], ALU_B=B[7:0], CI=0. Latch ALU_OUT into res[7:0] and ALU_CO into the carry register, then go to HI.
- ADD16, HI state: ALU_A=A[15:8], ALU_B=B[15:8], CI=carry. Latch res[15:8] and RSP_CO, then go to DONE.
- SUB16 uses the same sequence, with ALU_B set to the bitwise inverse of the B byte and LO CI=1 (two's complement through kADD). kSUB is never issued because it cannot chain borrow.
- NORM, NORM state, with work register w:
  - If w==0 at entry: go to DONE with data 0 and CNT 0.
  - Else if w[7]==1: go to DONE.
  - Else: drive ALU_OP=kSLL, ALU_A=w; latch w<=ALU_OUT and cnt<=cnt+1.
  - The maximum is 7 shifts.
- DONE: RSP_VALID=1 with all RSP_* stable. An edge with RSP_READY=1 returns to IDLE. A new request cannot be accepted in the same cycle.
- Outside LO/HI/NORM, ALU ports are driven to ALU_OP=kADD, ALU_A=ALU_B=0, CI=0.
- RSP_ZERO is computed from the registered result.

## Timing
- Reset (asynchronous, any state, including mid-command): state=IDLE and all registers cleared. The in-flight command is dropped with no response.
  - During reset: RSP_VALID=0, RSP_DATA=0, RSP_CO=0, RSP_ZERO=0, RSP_CNT=0, RSP_ERR=0, REQ_READY=1, ALU ports at idle values.
- Latency, counted from the accept edge to RSP_VALID rising:
  - ADD16/SUB16: 3 cycles (LO, HI, DONE).
  - NORM with k shifts: k+2 cycles.
  - Zero operand or error: 1 cycle.
- Backpressure: while RSP_READY=0, DONE holds indefinitely and REQ_READY=0.
- Throughput: at most one command in flight.
- REQ_* are sampled only on the accept edge; later changes are ignored.

## Configuration
- ALU_SEQ_NORM_EN defined: NORM is supported as above.
- Not defined: the NORM state and shift counter are removed.
  - A NORM command takes the error path: DONE after 1 cycle, RSP_ERR=1, RSP_DATA=0.
  - RSP_CNT is tied to 0.

## Structure
- The shared package `definitions` holds:
  - seq_cmd_t enum (CMD_ADD16=0, CMD_SUB16=1, CMD_NORM=2, CMD_RSVD=3);
  - seq_state_t enum (IDLE, LO, HI, NORM, DONE);
  - the ALU opcodes it already defines (kADD, kSLL), which are reused unchanged.
- No sub-module: the ALU stays instantiated by the parent, and alu_seq only drives and reads its ports.

## Test plan
- ADD16 0x12FF+0x0001 -> RSP_DATA=0x1300, CO=0, ZERO=0, RSP_VALID exactly 3 cycles after accept.
- ADD16 0xFFFF+0x0001 -> RSP_DATA=0x0000, CO=1, ZERO=1. SUB16 0x1000-0x0001 -> 0x0FFF, CO=1. SUB16 0x0000-0x0001 -> 0xFFFF, CO=0.
- NORM 0x05 -> RSP_DATA=0x00A0, CNT=5, RSP_VALID 7 cycles after accept. NORM 0x80 -> 0x0080, CNT=0, 2 cycles. NORM 0x00 -> 0, CNT=0, ZERO=1, 1 cycle.
- Cmd 3, and NORM without ALU_SEQ_NORM_EN -> RSP_ERR=1, data 0, RSP_VALID 1 cycle after accept.
- RSP_READY held low 4 cycles in DONE -> outputs stable, REQ_READY=0, REQ_VALID ignored. Accept occurs only on the cycle after the RSP_READY handshake.
- RESET_N pulsed low during HI of an ADD16 -> immediate IDLE, all outputs at reset values, no response. The next ADD16 completes normally.
